sram_pipe_model: RTL and testbench
==================================

# sram_pipe_model

Parametrised single-port SRAM behavioural model that sits on the SRAM-side request/response interface of a `tlul_adapter_sram` instance, behind the TL-UL fabric in the secure-boot playground.
- Generalises the fixed 1-cycle, 32-bit model with four additions: configurable data width, configurable read latency with fully pipelined reads, out-of-window error reporting, and a hardware zeroize sequencer.
- The zeroize sequencer wipes the array one word per cycle while back-pressuring the adapter.

## Interface
- `SramAw`, 14: word-address width of `addr_i`.
- `SramDw`, 32: data width; multiple of 8.
- `NumWords`, 1<<SramAw: implemented words; 1 ≤ NumWords ≤ 2^SramAw.
- `ReadLatency`, 1: cycles from read grant to `rvalid_o`; legal range 1..4.
- `BaseAddr`, 32'h0: system byte base address of the window; word-aligned.
- `InitHex`, "": hex file loaded into the array at time 0; empty means no load.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `req_i` in 1: request from the adapter.
- `gnt_o` out 1: request accepted this cycle.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in SramAw: system word address (byte address >> 2), truncated.
- `wdata_i` in SramDw: write data.
- `wmask_i` in SramDw/8: byte-enable mask.
- `rdata_o` out SramDw: read data.
- `rvalid_o` out 1: read response valid.
- `rerror_o` out 2: response error; bit0 = out-of-window, bit1 = 0.
- `zeroize_i` in 1: level request to wipe the array.
- `zeroize_busy_o` out 1: wipe in progress.
- `zeroize_done_o` out 1: one-cycle pulse when the wipe completes.

## Operation
- **Local address:** `local = (addr_i - BaseAddr[SramAw+1:2]) mod 2^SramAw`.
- **Out-of-window (OOB):** an access is OOB when `local >= NumWords`.
- **FSM states:** IDLE, WIPE.
- **Grant:** `gnt_o = req_i & (state == IDLE) & ~zeroize_i` (combinational). Acceptance = `req_i & gnt_o`.
- **Accepted write:**
  - If in window, byte b of the word is updated with `wdata_i[8b+:8]` when `wmask_i[b]`; other bytes are unchanged.
  - If OOB, the write is dropped silently. Writes produce no response.
- **Accepted read:**
  - The array word is sampled at the accepting clock edge and enters a ReadLatency-deep valid/data/error pipeline.
  - In window: response carries the word with `rerror_o = 2'b00`.
  - OOB: `rdata_o = 0`, `rerror_o = 2'b01`.
- **Throughput:** one read per cycle sustained; responses return strictly in order.
- **Ordering:** a read accepted the cycle after a write to the same word returns the new data. Only one access can be accepted per cycle.
- **IDLE → WIPE:** when `zeroize_i = 1` in IDLE.
  - The wipe counter clears to 0 and `zeroize_busy_o` rises on the next cycle.
- **WIPE:**
  - Each cycle writes all-zero to word `counter`, then increments the counter.
  - `gnt_o = 0` throughout. `zeroize_i` is ignored.
  - Reads already in the pipeline complete normally with their pre-wipe sampled data.
- **WIPE → IDLE:** after the word NumWords-1 is written. `zeroize_done_o` pulses high in the cycle after that last write, coincident with `zeroize_busy_o` falling. If `zeroize_i` is still high, a new wipe starts from that IDLE cycle.
- **Reset values:**
  - `rvalid_o = 0`, `rdata_o = 0`, `rerror_o = 0`.
  - `zeroize_busy_o = 0`, `zeroize_done_o = 0`.
  - Pipeline cleared; state IDLE; counter 0.
- **Array retention:** contents are NOT reset. InitHex applies only at time 0.

## Timing
- **Read latency:** read granted at edge N → `rvalid_o` high for exactly one cycle after edge N+ReadLatency.
- **Response hold:** `rdata_o`/`rerror_o` hold the last response value while `rvalid_o` is low.
- **Write visibility:** a write takes effect at the accepting edge.
- **Wipe duration:** `zeroize_i` asserted in IDLE at cycle 0 → `gnt_o = 0` combinationally in cycle 0. `zeroize_busy_o` is high for cycles 1..NumWords. `zeroize_done_o` pulses in cycle NumWords+1, and `gnt_o` can go high again from that cycle.
- **Reset mid-wipe:**
  - Immediate return to IDLE with busy low and no done pulse.
  - Partially wiped contents remain.
  - In-flight reads are discarded, with no `rvalid_o` after reset release.
- **Simultaneous events:** `req_i` and `zeroize_i` in the same IDLE cycle → zeroize wins and the request is not granted.

## Test plan
- **Latency:** ReadLatency=3, BaseAddr=32'h1000_0000. Write 0xDEADBEEF, mask 4'hF, to addr_i = (0x1000_0004>>2). Read the same address → `rvalid_o` exactly 3 cycles after grant, `rdata_o = 0xDEADBEEF`, `rerror_o = 0`.
- **Byte mask:** word = 0xAAAAAAAA; write 0x11223344 with mask 4'b0101 → read returns 0xAA22AA44.
- **Pipelining:** ReadLatency=2. Four back-to-back reads of words holding 1,2,3,4 → four consecutive `rvalid_o` cycles with data 1,2,3,4; the gap between grant and response is constant.
- **Out-of-window:** NumWords=1024. Read local 1024 → `rvalid_o` with `rdata_o = 0`, `rerror_o = 2'b01`. Write 0x5 to local 1024, then read local 0 → word 0 unchanged.
- **Zeroize:** NumWords=16, all words 0xFFFFFFFF. Issue a read in cycle −1, then assert `zeroize_i` together with `req_i` in cycle 0.
  - `gnt_o = 0` in cycle 0; `zeroize_busy_o` high for cycles 1..16.
  - `zeroize_done_o` pulses in cycle 17.
  - The pending read returns 0xFFFFFFFF.
  - All later reads return 0.
- **Reset mid-wipe:** assert `rst_ni` low at wipe cycle 8 → all outputs reach their reset values immediately. After release, words 0..6 read 0 and word 15 reads its pre-wipe value.

Source files
------------

// File: rtl/sram_pipe_model.sv
// sram_pipe_model: single-port SRAM behavioural model for the SRAM side of a tlul_adapter_sram.
//
// Reads are fully pipelined with a configurable latency. Accesses outside the
// [BaseAddr, BaseAddr + NumWords words) window are flagged on rerror_o[0]. A zeroize
// sequencer wipes the array one word per cycle while holding off new requests.
module sram_pipe_model #(
  parameter int unsigned SramAw      = 14,
  parameter int unsigned SramDw      = 32,
  parameter int unsigned NumWords    = 1 << SramAw,
  parameter int unsigned ReadLatency = 1,
  parameter logic [31:0] BaseAddr    = 32'h0,
  parameter string       InitHex     = ""
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic                we_i,
  input  logic [SramAw-1:0]   addr_i,
  input  logic [SramDw-1:0]   wdata_i,
  input  logic [SramDw/8-1:0] wmask_i,
  output logic [SramDw-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic [1:0]          rerror_o,
  input  logic                zeroize_i,
  output logic                zeroize_busy_o,
  output logic                zeroize_done_o
);

  localparam int unsigned       NumBytes  = SramDw / 8;
  localparam int unsigned       IdxW      = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [31:0]       BaseWord  = BaseAddr >> 2;
  localparam logic [SramAw-1:0] BaseLocal = BaseWord[SramAw-1:0];
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NumWords - 1);

  typedef enum logic [0:0] {StIdle, StWipe} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  logic [SramDw-1:0] mem [NumWords];

  // Address decode: window-relative word index, wrapping modulo 2^SramAw.
  logic [SramAw-1:0] local_addr;
  logic [IdxW-1:0]   mem_idx;
  logic              oob;
  logic              wr_en, rd_en;
  logic [SramDw-1:0] rd_word;

  always_comb begin
    local_addr = addr_i - BaseLocal;
    oob        = (32'(local_addr) >= NumWords);
    mem_idx    = local_addr[IdxW-1:0];
    gnt_o      = req_i & (state_q == StIdle) & ~zeroize_i;
    wr_en      = gnt_o & we_i & ~oob;
    rd_en      = gnt_o & ~we_i;
    rd_word    = oob ? '0 : mem[mem_idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (zeroize_i) begin
          state_d = StWipe;
          cnt_d   = '0;
        end
      end
      StWipe: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign zeroize_busy_o = (state_q == StWipe);
  assign zeroize_done_o = done_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (state_q == StWipe) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (wmask_i[b]) begin
          mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Data/error stages only advance behind a valid, so the last stage holds the
  // previous response while rvalid_o is low.
  logic [ReadLatency-1:0] vld_q;
  logic [ReadLatency-1:0] err_q;
  logic [SramDw-1:0]      dat_q [ReadLatency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int unsigned k = 0; k < ReadLatency; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en;
      if (rd_en) begin
        dat_q[0] <= rd_word;
        err_q[0] <= oob;
      end
      for (int unsigned k = 1; k < ReadLatency; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
          err_q[k] <= err_q[k-1];
        end
      end
    end
  end

  assign rvalid_o = vld_q[ReadLatency-1];
  assign rdata_o  = dat_q[ReadLatency-1];
  assign rerror_o = {1'b0, err_q[ReadLatency-1]};

endmodule

// File: tb/tb_sram_pipe_model.sv
// Directed bench for sram_pipe_model: latency, byte mask, pipelining, out-of-window,
// zeroize timing and reset in the middle of a wipe.
module tb_sram_pipe_model;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wmask_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic [1:0]  rerror_o;
    logic        zeroize_i;
    logic        zeroize_busy_o;
    logic        zeroize_done_o;

    int total = 0;
    int bad   = 0;

    sram_pipe_model #(
        .SramAw     (12),
        .SramDw     (32),
        .NumWords   (1024),
        .ReadLatency(3),
        .BaseAddr   (32'h1000_0000),
        .InitHex    ("")
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .wmask_i       (wmask_i),
        .rdata_o       (rdata_o),
        .rvalid_o      (rvalid_o),
        .rerror_o      (rerror_o),
        .zeroize_i     (zeroize_i),
        .zeroize_busy_o(zeroize_busy_o),
        .zeroize_done_o(zeroize_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        wmask_i = m;
        tick();
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    // Read with exact latency check: rvalid low for two cycles, high in the third.
    task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp_d,
                            input logic [1:0] exp_e);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        #1;
        check({tag, "_gnt"}, gnt_o, 1);
        tick();
        req_i = 1'b0;
        check({tag, "_v1"}, rvalid_o, 0);
        tick();
        check({tag, "_v2"}, rvalid_o, 0);
        tick();
        check({tag, "_v3"}, rvalid_o, 1);
        check({tag, "_data"}, rdata_o, exp_d);
        check({tag, "_err"}, rerror_o, exp_e);
    endtask

    logic [31:0] word_addr;
    logic [11:0] a_dead;

    initial begin
        rst_ni    = 1'b0;
        req_i     = 1'b0;
        we_i      = 1'b0;
        addr_i    = '0;
        wdata_i   = '0;
        wmask_i   = '0;
        zeroize_i = 1'b0;
        #2;
        check("rst_rvalid", rvalid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_rerror", rerror_o, 0);
        check("rst_busy", zeroize_busy_o, 0);
        check("rst_done", zeroize_done_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Latency and read-after-write.
        word_addr = 32'h1000_0004 >> 2;
        a_dead    = word_addr[11:0];
        wr(a_dead, 32'hDEAD_BEEF, 4'hF);
        rd_check("lat", a_dead, 32'hDEAD_BEEF, 2'b00);
        tick();
        check("lat_pulse", rvalid_o, 0);
        check("lat_hold", rdata_o, 32'hDEAD_BEEF);

        // Byte mask.
        wr(12'd2, 32'hAAAA_AAAA, 4'hF);
        wr(12'd2, 32'h1122_3344, 4'b0101);
        rd_check("mask", 12'd2, 32'hAA22_AA44, 2'b00);

        // Four back-to-back reads of 1..4.
        for (int i = 0; i < 4; i++) wr(12'(10 + i), 32'(i + 1), 4'hF);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 12'd10;
        #1;
        check("pipe_gnt", gnt_o, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i < 3) addr_i = 12'(11 + i);
            else req_i = 1'b0;
            check("pipe_vld", rvalid_o, (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
            if (i >= 2 && i <= 5) check("pipe_data", rdata_o, 32'(i - 1));
        end

        // Out-of-window read and dropped write.
        rd_check("oob_rd", 12'h400, 32'h0, 2'b01);
        wr(12'd0, 32'h1234_5678, 4'hF);
        wr(12'h400, 32'h5, 4'hF);
        rd_check("oob_wr", 12'd0, 32'h1234_5678, 2'b00);

        // Zeroize with a read in flight and a colliding request.
        for (int i = 0; i < 1024; i++) wr(12'(i), 32'hFFFF_FFFF, 4'hF);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 12'd5;
        #1;
        check("zr_pre_gnt", gnt_o, 1);
        tick();
        zeroize_i = 1'b1;
        #1;
        check("zr_gnt0", gnt_o, 0);
        check("zr_busy0", zeroize_busy_o, 0);
        tick();
        zeroize_i = 1'b0;
        for (int k = 1; k <= 1025; k++) begin
            check("zr_busy", zeroize_busy_o, (k <= 1024) ? 32'd1 : 32'd0);
            check("zr_done", zeroize_done_o, (k == 1025) ? 32'd1 : 32'd0);
            check("zr_vld", rvalid_o, (k == 2) ? 32'd1 : 32'd0);
            if (k == 2) check("zr_pending", rdata_o, 32'hFFFF_FFFF);
            #1;
            check("zr_gnt", gnt_o, (k == 1025) ? 32'd1 : 32'd0);
            tick();
        end
        req_i = 1'b0;
        check("zr_post_v1", rvalid_o, 0);
        tick();
        check("zr_post_v2", rvalid_o, 0);
        tick();
        check("zr_post_v3", rvalid_o, 1);
        check("zr_post_data", rdata_o, 32'h0);
        rd_check("zr_last", 12'd1023, 32'h0, 2'b00);

        // Reset in wipe cycle 8.
        for (int i = 0; i < 16; i++) wr(12'(i), 32'hFFFF_FFFF, 4'hF);
        wr(12'd1023, 32'hFFFF_FFFF, 4'hF);
        rd_check("rw_pre", 12'd15, 32'hFFFF_FFFF, 2'b00);
        zeroize_i = 1'b1;
        tick();
        zeroize_i = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        check("rw_busy8", zeroize_busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check("rw_busy", zeroize_busy_o, 0);
        check("rw_done", zeroize_done_o, 0);
        check("rw_rvalid", rvalid_o, 0);
        check("rw_rdata", rdata_o, 0);
        check("rw_rerror", rerror_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("rw_nodone", zeroize_done_o, 0);
        rd_check("rw_w0", 12'd0, 32'h0, 2'b00);
        rd_check("rw_w6", 12'd6, 32'h0, 2'b00);
        rd_check("rw_w7", 12'd7, 32'hFFFF_FFFF, 2'b00);
        rd_check("rw_w15", 12'd15, 32'hFFFF_FFFF, 2'b00);
        rd_check("rw_w1023", 12'd1023, 32'hFFFF_FFFF, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
